// File: rtl/uart_tx_param_if.sv
// Valid/ready handshake and serial-line bundle for uart_tx_param.
// The source side uses the master modport; the transmitter uses the slave modport.
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 DataOut;
  logic                 charTX;
  logic                 busy;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, DataOut, charTX, busy
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, DataOut, charTX, busy
  );
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional odd/even parity and one or two stop bits, each held for CLK_DIV clocks.
module uart_tx_param #(
  parameter int CLK_DIV   = 434,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  uart_tx_param_if.slave   bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  localparam logic [15:0] LP_DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] LP_DIV_PRE   = 16'(CLK_DIV - 2);
  localparam logic [3:0]  LP_DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]  LP_STOP_LAST = 4'(STOP_BITS - 1);

  if ((CLK_DIV < 2) || (CLK_DIV > 65535) || (DATA_BITS < 5) || (DATA_BITS > 9) ||
      (PARITY < 0) || (PARITY > 2) || (STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_param_check
    $error("uart_tx_param: illegal parameter value");
  end

  // Odd mode inverts the XOR so that the total count of ones including the parity bit is odd.
  function automatic logic f_parity(input logic [DATA_BITS-1:0] d);
    if (PARITY == 1) begin
      f_parity = ~(^d);
    end else begin
      f_parity = ^d;
    end
  endfunction

  logic [2:0]           r_state;
  logic [15:0]          r_timer;
  logic [3:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bit;
  logic                 r_data_out;
  logic                 r_char_tx;
  logic                 r_busy;

  logic w_ready;
  logic w_handshake;
  logic w_bit_end;

  assign w_ready     = (r_state == S_IDLE);
  assign w_handshake = bus.tx_valid && w_ready;
  assign w_bit_end   = (r_timer == LP_DIV_LAST);

  assign bus.tx_ready = w_ready;
  assign bus.DataOut  = r_data_out;
  assign bus.charTX   = r_char_tx;
  assign bus.busy     = r_busy;

  // Frame sequencer; DataOut is loaded with the level of the bit about to start.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_timer    <= 16'd0;
      r_bit_idx  <= 4'd0;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_data_out <= 1'b1;
      r_char_tx  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_char_tx <= (r_state == S_STOP) && (r_bit_idx == LP_STOP_LAST) && (r_timer == LP_DIV_PRE);

      if ((r_state == S_IDLE) || w_bit_end) begin
        r_timer <= 16'd0;
      end else begin
        r_timer <= r_timer + 16'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_handshake) begin
            r_shift    <= bus.tx_data;
            r_par_bit  <= f_parity(bus.tx_data);
            r_bit_idx  <= 4'd0;
            r_data_out <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_data_out <= r_shift[0];
            r_state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_shift <= r_shift >> 1;
            if (r_bit_idx == LP_DATA_LAST) begin
              r_bit_idx <= 4'd0;
              if (PARITY != 0) begin
                r_data_out <= r_par_bit;
                r_state    <= S_PAR;
              end else begin
                r_data_out <= 1'b1;
                r_state    <= S_STOP;
              end
            end else begin
              r_bit_idx  <= r_bit_idx + 4'd1;
              r_data_out <= r_shift[1];
            end
          end
        end
        S_PAR: begin
          if (w_bit_end) begin
            r_data_out <= 1'b1;
            r_state    <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            if (r_bit_idx == LP_STOP_LAST) begin
              r_bit_idx <= 4'd0;
              r_busy    <= 1'b0;
              r_state   <= S_IDLE;
            end else begin
              r_bit_idx <= r_bit_idx + 4'd1;
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_bit_idx  <= 4'd0;
          r_data_out <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param over several parameter sets sharing one clock and reset.
module tb_uart_tx_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic       v_valid [5];
  logic [8:0] v_data  [5];
  logic       v_rdy   [5];
  logic       v_dout  [5];
  logic       v_chtx  [5];
  logic       v_busy  [5];
  logic       exp_q[$];

  // 0: div4 8N1, 1: div4 8E1, 2: div4 8O1, 3: div3 7N2, 4: defaults
  uart_tx_param_if #(.DATA_BITS(8)) if_a ();
  uart_tx_param_if #(.DATA_BITS(8)) if_e ();
  uart_tx_param_if #(.DATA_BITS(8)) if_o ();
  uart_tx_param_if #(.DATA_BITS(7)) if_b ();
  uart_tx_param_if #(.DATA_BITS(8)) if_d ();

  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (.CLOCK_50(clk), .reset(rst), .bus(if_a));
  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_e (.CLOCK_50(clk), .reset(rst), .bus(if_e));
  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_o (.CLOCK_50(clk), .reset(rst), .bus(if_o));
  uart_tx_param #(.CLK_DIV(3), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_b (.CLOCK_50(clk), .reset(rst), .bus(if_b));
  uart_tx_param u_d (.CLOCK_50(clk), .reset(rst), .bus(if_d));

  assign if_a.tx_data = v_data[0][7:0];
  assign if_e.tx_data = v_data[1][7:0];
  assign if_o.tx_data = v_data[2][7:0];
  assign if_b.tx_data = v_data[3][6:0];
  assign if_d.tx_data = v_data[4][7:0];
  assign if_a.tx_valid = v_valid[0];
  assign if_e.tx_valid = v_valid[1];
  assign if_o.tx_valid = v_valid[2];
  assign if_b.tx_valid = v_valid[3];
  assign if_d.tx_valid = v_valid[4];
  assign v_rdy[0] = if_a.tx_ready;  assign v_dout[0] = if_a.DataOut;
  assign v_rdy[1] = if_e.tx_ready;  assign v_dout[1] = if_e.DataOut;
  assign v_rdy[2] = if_o.tx_ready;  assign v_dout[2] = if_o.DataOut;
  assign v_rdy[3] = if_b.tx_ready;  assign v_dout[3] = if_b.DataOut;
  assign v_rdy[4] = if_d.tx_ready;  assign v_dout[4] = if_d.DataOut;
  assign v_chtx[0] = if_a.charTX;   assign v_busy[0] = if_a.busy;
  assign v_chtx[1] = if_e.charTX;   assign v_busy[1] = if_e.busy;
  assign v_chtx[2] = if_o.charTX;   assign v_busy[2] = if_o.busy;
  assign v_chtx[3] = if_b.charTX;   assign v_busy[3] = if_b.busy;
  assign v_chtx[4] = if_d.charTX;   assign v_busy[4] = if_d.busy;

  // Called at a negedge; pushes the expected bit levels, waits for the handshake, then
  // checks DataOut/charTX/tx_ready/busy on every clock of the frame.
  task automatic send_frame(input int idx, input int div, input int nbits, input int par,
                            input int stops, input logic [8:0] data, input logic [8:0] next_data,
                            input logic keep, output int waited);
    int   ones;
    int   total;
    logic exp_b;
    logic exp_c;
    ones = 0;
    v_data[idx]  = data;
    v_valid[idx] = 1'b1;
    exp_q.push_back(1'b0);
    for (int i = 0; i < nbits; i++) begin
      exp_q.push_back(data[i]);
      ones += int'(data[i]);
    end
    if (par == 2) exp_q.push_back(((ones % 2) != 0) ? 1'b1 : 1'b0);
    if (par == 1) exp_q.push_back(((ones % 2) == 0) ? 1'b1 : 1'b0);
    for (int i = 0; i < stops; i++) exp_q.push_back(1'b1);
    total  = exp_q.size() * div;
    waited = 0;
    while (v_rdy[idx] !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    n_tests++;
    if (v_rdy[idx] !== 1'b1) begin
      n_fail++;
      $display("FAIL handshake_timeout dut%0d: tx_ready=%b required 1", idx, v_rdy[idx]);
      exp_q.delete();
      v_valid[idx] = 1'b0;
      return;
    end
    n_tests++;
    if (v_dout[idx] !== 1'b1 || v_chtx[idx] !== 1'b0 || v_busy[idx] !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_before_frame dut%0d: DataOut=%b charTX=%b busy=%b required 1 0 0",
               idx, v_dout[idx], v_chtx[idx], v_busy[idx]);
    end
    @(posedge clk);
    #1;
    v_data[idx] = next_data;
    if (!keep) v_valid[idx] = 1'b0;
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      exp_b = exp_q[0];
      exp_c = (c == total - 1) ? 1'b1 : 1'b0;
      n_tests++;
      if (v_dout[idx] !== exp_b) begin
        n_fail++;
        $display("FAIL dataout dut%0d data=%h cycle %0d: got %b required %b", idx, data, c, v_dout[idx], exp_b);
      end
      n_tests++;
      if (v_chtx[idx] !== exp_c) begin
        n_fail++;
        $display("FAIL chartx dut%0d data=%h cycle %0d: got %b required %b", idx, data, c, v_chtx[idx], exp_c);
      end
      n_tests++;
      if (v_rdy[idx] !== 1'b0 || v_busy[idx] !== 1'b1) begin
        n_fail++;
        $display("FAIL ready_busy dut%0d cycle %0d: tx_ready=%b busy=%b required 0 1", idx, c, v_rdy[idx], v_busy[idx]);
      end
      if ((c % div) == div - 1) void'(exp_q.pop_front());
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain dut%0d: %0d bits left required 0", idx, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_idle(input int idx, input string tag);
    n_tests++;
    if (v_dout[idx] !== 1'b1 || v_rdy[idx] !== 1'b1 || v_busy[idx] !== 1'b0 || v_chtx[idx] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s dut%0d: DataOut=%b tx_ready=%b busy=%b charTX=%b required 1 1 0 0",
               tag, idx, v_dout[idx], v_rdy[idx], v_busy[idx], v_chtx[idx]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) check_idle(i, "reset_state");
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_idle();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      check_idle(0, "idle_hold");
      check_idle(4, "idle_hold");
    end
  endtask

  task automatic test_8n1();
    int w;
    send_frame(0, 4, 8, 0, 1, 9'h0A5, 9'h000, 1'b0, w);
  endtask

  task automatic test_parity();
    int w;
    send_frame(1, 4, 8, 2, 1, 9'h055, 9'h0FF, 1'b0, w);
    send_frame(2, 4, 8, 1, 1, 9'h055, 9'h0FF, 1'b0, w);
    send_frame(1, 4, 8, 2, 1, 9'h007, 9'h000, 1'b0, w);
  endtask

  task automatic test_back_to_back();
    int w;
    send_frame(3, 3, 7, 0, 2, 9'h041, 9'h042, 1'b1, w);
    send_frame(3, 3, 7, 0, 2, 9'h042, 9'h07F, 1'b0, w);
    n_tests++;
    if (w != 1) begin
      n_fail++;
      $display("FAIL idle_gap dut3: %0d idle cycles required 1", w);
    end
  endtask

  task automatic test_reset_midframe();
    int w;
    v_data[0]  = 9'h0A5;
    v_valid[0] = 1'b1;
    @(posedge clk);
    #1 v_valid[0] = 1'b0;
    repeat (18) @(negedge clk);
    n_tests++;
    if (v_dout[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe_bit3: DataOut=%b required 0", v_dout[0]);
    end
    #1 rst = 1'b1;
    #1;
    check_idle(0, "async_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      check_idle(0, "after_reset");
    end
    send_frame(0, 4, 8, 0, 1, 9'h03C, 9'h0C3, 1'b0, w);
  endtask

  task automatic test_default_div();
    int w;
    send_frame(4, 434, 8, 0, 1, 9'h000, 9'h0FF, 1'b0, w);
    send_frame(4, 434, 8, 0, 1, 9'h0FF, 9'h000, 1'b0, w);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      v_valid[i] = 1'b0;
      v_data[i]  = 9'h000;
    end
    test_reset();
    test_idle();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_reset_midframe();
    test_default_div();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
